// File: rtl/regfile_mp.sv
// Parametrised multi-port register file: registered reads with valid flags,
// optional zero register, optional write-through bypass and write-collision flag.
module regfile_mp #(
  parameter int DataWidth     = 32,
  parameter int AddrWidth     = 5,
  parameter int NumReadPorts  = 2,
  parameter int NumWritePorts = 1,
  parameter int ZeroReg       = 1,
  parameter int WriteThrough  = 1
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NumReadPorts-1:0]           rd_req_i,
  input  logic [NumReadPorts*AddrWidth-1:0] rd_addr_i,
  output logic [NumReadPorts*DataWidth-1:0] rd_data_o,
  output logic [NumReadPorts-1:0]           rd_valid_o,
  input  logic [NumWritePorts-1:0]          we_i,
  input  logic [NumWritePorts*AddrWidth-1:0] waddr_i,
  input  logic [NumWritePorts*DataWidth-1:0] wdata_i,
  output logic                              wcollide_o
);

  localparam int NumWords = 2 ** AddrWidth;

  logic [DataWidth-1:0] mem_reg [NumWords];
  logic                 collide_reg;
  logic                 collide_next;

  // Ascending port order makes the highest-index write win on a shared address.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumWords; i++) begin
        mem_reg[i] <= '0;
      end
    end else begin
      for (int w = 0; w < NumWritePorts; w++) begin
        if (we_i[w] && !(ZeroReg != 0 && waddr_i[w*AddrWidth +: AddrWidth] == '0)) begin
          mem_reg[waddr_i[w*AddrWidth +: AddrWidth]] <= wdata_i[w*DataWidth +: DataWidth];
        end
      end
    end
  end

  // Collisions count even on address 0, where the write itself is dropped.
  always_comb begin
    collide_next = 1'b0;
    for (int i = 0; i < NumWritePorts; i++) begin
      for (int j = i + 1; j < NumWritePorts; j++) begin
        if (we_i[i] && we_i[j] &&
            waddr_i[i*AddrWidth +: AddrWidth] == waddr_i[j*AddrWidth +: AddrWidth]) begin
          collide_next = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      collide_reg <= 1'b0;
    end else begin
      collide_reg <= collide_next;
    end
  end

  assign wcollide_o = collide_reg;

  for (genvar gi = 0; gi < NumReadPorts; gi++) begin : g_rd
    logic [AddrWidth-1:0] addr;
    logic [DataWidth-1:0] val_next;
    logic [DataWidth-1:0] data_reg;
    logic                 valid_reg;

    assign addr = rd_addr_i[gi*AddrWidth +: AddrWidth];

    always_comb begin
      val_next = mem_reg[addr];
      if (WriteThrough != 0) begin
        for (int w = 0; w < NumWritePorts; w++) begin
          if (we_i[w] && waddr_i[w*AddrWidth +: AddrWidth] == addr) begin
            val_next = wdata_i[w*DataWidth +: DataWidth];
          end
        end
      end
      if (ZeroReg != 0 && addr == '0) begin
        val_next = '0;
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        data_reg  <= '0;
        valid_reg <= 1'b0;
      end else begin
        valid_reg <= rd_req_i[gi];
        if (rd_req_i[gi]) begin
          data_reg <= val_next;
        end
      end
    end

    assign rd_data_o[gi*DataWidth +: DataWidth] = data_reg;
    assign rd_valid_o[gi]                       = valid_reg;
  end

endmodule
